// File: rtl/renas_boot_pkg.sv
// rtl/renas_boot_pkg.sv - shared state type and default widths for the boot loader
package renas_boot_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } boot_state_e;

endpackage

// File: rtl/renas_boot_timeout.sv
// rtl/renas_boot_timeout.sv - saturating down-counter that flags the last allowed wait cycle
module renas_boot_timeout
    import renas_boot_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= CNT_W'(LIMIT);
        end else if (clear) begin
            remaining <= CNT_W'(LIMIT);
        end else if (enable && remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // True when the next enabled edge is the LIMIT-th one since the last clear.
    assign expired = (remaining <= CNT_W'(1));

endmodule

// File: rtl/renas_boot_loader.sv
// rtl/renas_boot_loader.sv - copies the boot ROM into instruction memory, then releases the core
module renas_boot_loader
    import renas_boot_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PROG_WORDS  = 256,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              boot_err,
    output logic [DATA_W-1:0] checksum
);

    // One spare bit so idx can hold PROG_WORDS itself for the final compare.
    localparam int IDX_W = $clog2(PROG_WORDS) + 1;

    boot_state_e      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             to_expired;

    assign idx_next = idx + IDX_W'(1);

    renas_boot_timeout #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == LOAD),
        .enable (state == WRITE && !mem_ready),
        .expired(to_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            idx       <= '0;
            rom_addr  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(BASE_ADDR);
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                FETCH: begin
                    rom_addr <= ADDR_W'(idx);
                    state    <= LOAD;
                end
                LOAD: begin
                    mem_wdata <= rom_data;
                    mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    // Acceptance wins over a timeout landing on the same edge.
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        checksum <= checksum + mem_wdata;
                        idx      <= idx_next;
                        if (idx_next == IDX_W'(PROG_WORDS)) begin
                            state     <= DONE;
                            cpu_rst_n <= 1'b1;
                            boot_done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (to_expired) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        boot_err <= 1'b1;
                        state    <= ERROR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_renas_boot_loader.sv
// tb/tb_renas_boot_loader.sv - timeline-model bench for the boot loader
module tb_renas_boot_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int BASE   = 'h3FE;
    localparam int TO     = 8;
    localparam int INF    = 1 << 30;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 1'b0;
    logic              cpu_rst_n;
    logic              boot_done;
    logic              boot_err;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] rom_mem [N];
    int                stall [N];
    int                fetch_e [N];
    int                load_e [N];
    int                acc_e [N];
    int                done_e;
    int                err_e;
    int                total = 0;
    int                bad = 0;
    logic [ADDR_W-1:0] acc_addr [$];

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr[1:0]];

    renas_boot_loader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PROG_WORDS (N),
        .BASE_ADDR  (BASE),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .cpu_rst_n(cpu_rst_n),
        .boot_done(boot_done),
        .boot_err (boot_err),
        .checksum (checksum)
    );

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    // Word i: fetched at edge S+1, loaded at S+2, accepted after its stall, S advancing per word.
    task automatic plan();
        int s;
        s      = 0;
        done_e = INF;
        err_e  = INF;
        for (int i = 0; i < N; i++) begin
            fetch_e[i] = INF;
            load_e[i]  = INF;
            acc_e[i]   = INF;
        end
        for (int i = 0; i < N; i++) begin
            fetch_e[i] = s + 1;
            load_e[i]  = s + 2;
            if (stall[i] >= TO) begin
                err_e = s + 2 + TO;
                break;
            end
            acc_e[i] = s + 3 + stall[i];
            s        = acc_e[i];
        end
        if (err_e == INF) done_e = s;
    endtask

    task automatic check_at(input int t);
        logic [31:0] e_ra;
        logic [31:0] e_ma;
        logic [31:0] e_wd;
        logic [31:0] e_sum;
        logic        e_req;
        e_ra  = 0;
        e_ma  = BASE;
        e_wd  = 0;
        e_sum = 0;
        e_req = 0;
        for (int i = 0; i < N; i++) begin
            if (fetch_e[i] <= t) e_ra = i;
            if (load_e[i] <= t) begin
                e_ma = (BASE + i) % (1 << ADDR_W);
                e_wd = rom_mem[i];
            end
            if (load_e[i] <= t && t < acc_e[i] && t < err_e) e_req = 1'b1;
            if (acc_e[i] <= t) e_sum = e_sum + rom_mem[i];
        end
        chk("rom_addr", t, 32'(rom_addr), e_ra);
        chk("mem_req", t, 32'(mem_req), 32'(e_req));
        chk("mem_we", t, 32'(mem_we), 32'(e_req));
        chk("mem_addr", t, 32'(mem_addr), e_ma);
        chk("mem_wdata", t, mem_wdata, e_wd);
        chk("checksum", t, checksum, e_sum);
        chk("boot_done", t, 32'(boot_done), 32'(t >= done_e));
        chk("cpu_rst_n", t, 32'(cpu_rst_n), 32'(t >= done_e));
        chk("boot_err", t, 32'(boot_err), 32'(t >= err_e));
    endtask

    // Memory side: low through the planned stall, high on the accepting edge, random elsewhere.
    task automatic drive_ready(input int e);
        logic r;
        r = 1'($urandom);
        for (int i = 0; i < N; i++) begin
            if (load_e[i] < e && e <= acc_e[i] && e <= err_e) r = (e == acc_e[i]);
        end
        mem_ready = r;
    endtask

    task automatic run_case(input int abort_at, input bit use_lit, input int lit_done,
                            input int lit_err, input logic [31:0] lit_sum);
        int first_done;
        int first_err;
        int end_t;
        first_done = -1;
        first_err  = -1;
        plan();
        acc_addr.delete();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'($urandom);
        @(negedge clk);
        check_at(0);
        rst_n = 1'b1;
        drive_ready(1);
        end_t = ((err_e != INF) ? err_e : done_e) + 4;
        for (int t = 1; t <= end_t; t++) begin
            @(negedge clk);
            check_at(t);
            if (boot_done === 1'b1 && first_done < 0) first_done = t;
            if (boot_err === 1'b1 && first_err < 0) first_err = t;
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("async_mem_req", t, 32'(mem_req), 0);
                chk("async_rom_addr", t, 32'(rom_addr), 0);
                chk("async_checksum", t, checksum, 0);
                return;
            end
            drive_ready(t + 1);
            if (mem_req && mem_ready) acc_addr.push_back(mem_addr);
        end
        if (use_lit) begin
            chk("done_edge", end_t, first_done, lit_done);
            chk("err_edge", end_t, first_err, lit_err);
            chk("final_sum", end_t, checksum, lit_sum);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_addr [N];
        exp_addr   = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        rom_mem[0] = 32'h11;
        rom_mem[1] = 32'h22;
        rom_mem[2] = 32'h33;
        rom_mem[3] = 32'h44;

        stall = '{0, 0, 0, 0};
        run_case(-1, 1'b1, 12, -1, 32'hAA);
        chk("addr_count", 0, acc_addr.size(), N);
        for (int i = 0; i < N && i < acc_addr.size(); i++) chk("addr_seq", i, 32'(acc_addr[i]), 32'(exp_addr[i]));

        stall = '{0, 0, 5, 0};
        run_case(-1, 1'b1, 17, -1, 32'hAA);
        stall = '{9, 0, 0, 0};
        run_case(-1, 1'b1, -1, 10, 32'h0);
        stall = '{7, 0, 0, 0};
        run_case(-1, 1'b1, 19, -1, 32'hAA);
        stall = '{0, 0, 8, 0};
        run_case(-1, 1'b1, -1, 16, 32'h33);
        stall = '{0, 0, 3, 0};
        run_case(9, 1'b0, 0, 0, 32'h0);
        stall = '{0, 0, 0, 0};
        run_case(-1, 1'b1, 12, -1, 32'hAA);

        repeat (40) begin
            for (int i = 0; i < N; i++) begin
                rom_mem[i] = $urandom;
                stall[i]   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 2));
            end
            run_case(-1, 1'b0, 0, 0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/renas_boot_loader.md
Name: renas_boot_loader

Overview:
- Program loader in renas_mcu_top, running in the clk domain directly after the top-level reset.
- Copies PROG_WORDS words from a synchronous boot ROM into instruction memory over a req/ready write port.
- Holds the core in reset (cpu_rst_n low) until the copy completes.
- Reports a running checksum, and reports an error if the memory side fails to respond.

Parameters:
- ADDR_W, 10: word-address width of the ROM and memory ports.
- DATA_W, 32: data width.
- PROG_WORDS, 256: number of words to copy, 1..2**ADDR_W.
- BASE_ADDR, 0: memory word address that receives ROM word 0.
- TIMEOUT_CYC, 255: maximum number of WRITE cycles to wait for mem_ready before ERROR.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  ADDR_W  boot ROM word address.
- rom_data  in  DATA_W  ROM read data, valid one cycle after rom_addr.
- mem_req  out  1  write request to instruction memory.
- mem_we  out  1  write enable, equal to mem_req.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  memory accepts the write at this clk edge.
- cpu_rst_n  out  1  core reset, low while loading.
- boot_done  out  1  copy finished without error.
- boot_err  out  1  memory timeout occurred.
- checksum  out  DATA_W  sum, modulo 2**DATA_W, of all words written.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=FETCH, idx=0, rom_addr=0, mem_req=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst_n=0, boot_done=0, boot_err=0, checksum=0, timeout count=0.
- Registered outputs: all outputs are registered; there are no combinational paths from inputs to outputs.
- Word index: idx is $clog2(PROG_WORDS)+1 bits wide, so it never wraps before the final compare.
- FETCH state:
  - rom_addr = idx.
  - Next state is LOAD.
- LOAD state:
  - Capture rom_data into mem_wdata.
  - Set mem_addr = BASE_ADDR + idx, truncated to ADDR_W, so it wraps modulo 2**ADDR_W.
  - Assert mem_req and mem_we.
  - Clear the timeout count.
  - Next state is WRITE.
- WRITE state:
  - Hold mem_req, mem_addr and mem_wdata stable until an edge where mem_ready=1.
  - On that edge: deassert mem_req, add mem_wdata to checksum, increment idx.
  - If the incremented idx equals PROG_WORDS, go to DONE; otherwise go to FETCH.
  - On each edge with mem_ready=0, increment the timeout count.
  - When the timeout count reaches TIMEOUT_CYC with mem_ready still 0, go to ERROR and deassert mem_req.
- Precedence: mem_ready=1 on the same edge the count reaches TIMEOUT_CYC counts as acceptance, not timeout.
- Latency:
  - Each word takes 3 cycles when mem_ready is held high.
  - DONE is entered at edge 3*PROG_WORDS after reset release.
- DONE state (terminal):
  - Set cpu_rst_n=1 and boot_done=1 on the edge that enters DONE.
  - mem_req stays 0 and checksum is frozen.
- ERROR state (terminal):
  - Set boot_err=1.
  - cpu_rst_n stays 0 and boot_done stays 0.
  - mem_addr and checksum are frozen at the failing word.
- Exit from terminal states: only rst_n leaves DONE or ERROR.
- Reset mid-copy:
  - Outputs return to their reset values immediately (asynchronously), including mem_req dropping to 0.
  - The copy restarts from idx 0 with checksum cleared.
- Ignored inputs: mem_ready outside WRITE is ignored, and rom_data outside LOAD is ignored.

Decomposition:
- Package renas_boot_pkg:
  - enum boot_state_e {FETCH, LOAD, WRITE, DONE, ERROR}, 3-bit encoding.
  - Default constants for ADDR_W, DATA_W and TIMEOUT_CYC.
- Sub-module renas_boot_timeout: a loadable saturating down-counter with clear, enable and expired outputs. It is the only natural split; all other logic stays in one FSM module.

Test Plan:
- PROG_WORDS=4, BASE_ADDR=0x100, ROM={0x11,0x22,0x33,0x44}, mem_ready tied 1:
  - Writes go to 0x100..0x103 with the ROM data in order.
  - boot_done and cpu_rst_n rise at edge 12; checksum=0xAA.
  - mem_req is never high for more than one cycle per word.
- Same setup, mem_ready low for 5 cycles on word 2:
  - mem_addr=0x102 and mem_wdata=0x33 stay stable throughout the stall.
  - DONE is reached at edge 17; checksum=0xAA.
- TIMEOUT_CYC=8, mem_ready stuck 0:
  - ERROR is entered 8 cycles into WRITE of word 0; boot_err=1, mem_req=0.
  - cpu_rst_n=0, boot_done=0, checksum=0.
- mem_ready rises exactly on the TIMEOUT_CYC edge: the word is accepted, there is no error, and the FSM continues to FETCH.
- rst_n pulsed low during WRITE of word 2:
  - mem_req drops to 0 asynchronously.
  - After release, rom_addr=0, checksum=0, and the full copy completes with checksum=0xAA.
- BASE_ADDR=0x3FE, ADDR_W=10, PROG_WORDS=4: the address sequence is 0x3FE, 0x3FF, 0x000, 0x001 (wrap-around), and DONE is still reached.
